frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
Write-side sequencer and ping/pong arbiter for two Single_Buffer instances (buffer 0 and buffer 1) forming the frame double buffer. It accepts a stream of 32-bit pixel words and scatters them over bank/block/address of the current write buffer. It hands completed frames to the matrix read-out engine and swaps buffers only when the reader has released its buffer. Sits between the HDMI pixel packer and the double buffer; the read-out engine generates its own read addresses.

Parameters:
BANK_COUNT, 6, banks per Single_Buffer
BLOCK_COUNT, 2, blocks per bank
WORDS_PER_BLOCK, 562, 32-bit write words per block (port A depth used)
ADDR_W, $clog2(WORDS_PER_BLOCK), write address width
FRAME_WORDS, BANK_COUNT*BLOCK_COUNT*WORDS_PER_BLOCK, words per frame (derived, not overridable)

Ports:
I_clk  in  1  single clock; all logic on rising edge
I_reset  in  1  synchronous, active-high reset
I_frame_start  in  1  pulse; first word of a new frame follows
I_wr_valid  in  1  pixel word valid
I_wr_data  in  32  pixel word
O_wr_ready  out  1  word accepted when I_wr_valid && O_wr_ready
O_wr_en  out  1  write strobe to port A (cea), registered
O_wr_buf  out  1  target buffer of current write (0/1)
O_wr_bank  out  $clog2(BANK_COUNT)  target bank
O_wr_block  out  $clog2(BLOCK_COUNT)  target block
O_wr_addr  out  ADDR_W  port A address
O_wr_data  out  32  registered copy of accepted word
O_rd_buf  out  1  buffer owned by reader
O_rd_start  out  1  one-cycle pulse: O_rd_buf holds a new complete frame
I_rd_done  in  1  pulse: reader finished its buffer
O_drop_count  out  16  frames aborted by early I_frame_start, saturating

Behaviour:
- Reset values: state IDLE, O_wr_ready 0, O_wr_en 0, O_wr_buf 0, O_wr_bank/block/addr/data 0, O_rd_buf 1, O_rd_start 0, O_drop_count 0, rd_busy 0.
- States: IDLE, FILL, SWAP.
- IDLE: O_wr_ready=0; I_wr_valid ignored. I_frame_start -> FILL, counters cleared.
- FILL: O_wr_ready=1. Accepted word: next cycle O_wr_en=1 with O_wr_data and the current bank/block/addr; otherwise O_wr_en=0. Latency 1 cycle.
- Scatter order: bank fastest, then block, then addr (word n: bank=n%BANK_COUNT, block=(n/BANK_COUNT)%BLOCK_COUNT, addr=n/(BANK_COUNT*BLOCK_COUNT)). Counters are separate mod-N counters; no divider.
- Word FRAME_WORDS-1 accepted -> SWAP (its write still issues next cycle); O_wr_ready deasserts same edge.
- I_frame_start while in FILL: drop partial frame, counters restart at 0, stay FILL, O_drop_count+1 (saturate at 16'hFFFF). Word arriving in the same cycle as I_frame_start is word 0 of new frame.
- SWAP: O_wr_ready=0. If rd_busy==0 or I_rd_done==1 this cycle: O_rd_buf<=O_wr_buf, O_wr_buf<=~O_wr_buf, O_rd_start=1 next cycle, rd_busy<=1, -> IDLE. Otherwise wait (stall; upstream sees ready=0). I_frame_start in SWAP ignored (not counted).
- rd_busy: set on swap, cleared by I_rd_done; I_rd_done while rd_busy==0 is ignored. Swap has priority when both coincide (rd_busy ends 1).
- Writer never targets O_rd_buf while rd_busy=1 (invariant O_wr_buf != O_rd_buf after first swap).
- I_reset mid-frame: all state back to reset values next cycle; no O_wr_en after reset edge.

Test Plan:
- BANK_COUNT=2, BLOCK_COUNT=2, WORDS_PER_BLOCK=3; frame_start then 12 words 0..11 back-to-back -> O_wr_en stream (bank,block,addr): 0:(0,0,0) 1:(1,0,0) 2:(0,1,0) 3:(1,1,0) 4:(0,0,1) ... 11:(1,1,2), all O_wr_buf=0; one cycle later O_rd_start, O_rd_buf=0, O_wr_buf=1.
- Second frame while rd_busy (no I_rd_done) -> stays SWAP, ready=0, no swap; pulse I_rd_done -> swap within 1 cycle, O_rd_buf=1, O_wr_buf=0.
- I_rd_done in the exact cycle the 12th word lands in SWAP -> swap happens, rd_busy=1 afterward.
- frame_start after 5 words -> O_drop_count=1, next accepted word writes (0,0,0), frame still needs 12 words.
- I_wr_valid toggling 1/0 every cycle -> 12 writes, gaps on O_wr_en, same address order; I_wr_valid in IDLE -> no O_wr_en.
- I_reset asserted after 7 words -> next cycle all outputs at reset values, O_rd_buf=1, new frame starts at (0,0,0).

Source files
------------

// File: rtl/frame_buffer_ctrl.sv
// Write-side sequencer and ping/pong arbiter for the frame double buffer.
// Scatters accepted pixel words bank-fastest over the write buffer and hands full frames to the reader.
module frame_buffer_ctrl #(
  parameter int BANK_COUNT      = 6,
  parameter int BLOCK_COUNT     = 2,
  parameter int WORDS_PER_BLOCK = 562,
  parameter int ADDR_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                                          I_clk,
  input  logic                                          I_reset,
  input  logic                                          I_frame_start,
  input  logic                                          I_wr_valid,
  input  logic [31:0]                                   I_wr_data,
  output logic                                          O_wr_ready,
  output logic                                          O_wr_en,
  output logic                                          O_wr_buf,
  output logic [((BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1)-1:0]   O_wr_bank,
  output logic [((BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1)-1:0] O_wr_block,
  output logic [ADDR_W-1:0]                             O_wr_addr,
  output logic [31:0]                                   O_wr_data,
  output logic                                          O_rd_buf,
  output logic                                          O_rd_start,
  input  logic                                          I_rd_done,
  output logic [15:0]                                   O_drop_count
);

  localparam int BANK_W  = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
  localparam int BLOCK_W = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1;
  localparam logic [BANK_W-1:0]  BANK_MAX  = BANK_W'(BANK_COUNT - 1);
  localparam logic [BLOCK_W-1:0] BLOCK_MAX = BLOCK_W'(BLOCK_COUNT - 1);
  localparam logic [ADDR_W-1:0]  ADDR_MAX  = ADDR_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SWAP} state_t;

  state_t              r_state, w_next_state;
  logic [BANK_W-1:0]   r_bank, w_bank;
  logic [BLOCK_W-1:0]  r_block, w_block;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic                w_restart, w_accept, w_swap, w_last, w_wr_ready;
  logic                r_wr_en, r_wr_buf, r_rd_buf, r_rd_start, r_rd_busy;
  logic [BANK_W-1:0]   r_wr_bank;
  logic [BLOCK_W-1:0]  r_wr_block;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [31:0]         r_wr_data;
  logic [15:0]         r_drop_count;

  // A frame_start during FILL makes the word of that same cycle word 0 of the new frame.
  assign w_restart = (r_state == S_FILL) && I_frame_start;
  assign w_bank    = w_restart ? '0 : r_bank;
  assign w_block   = w_restart ? '0 : r_block;
  assign w_addr    = w_restart ? '0 : r_addr;
  assign w_last    = (w_bank == BANK_MAX) && (w_block == BLOCK_MAX) && (w_addr == ADDR_MAX);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_wr_ready   = 1'b0;
    w_accept     = 1'b0;
    w_swap       = 1'b0;
    unique case (r_state)
      S_IDLE: if (I_frame_start) w_next_state = S_FILL;
      S_FILL: begin
        w_wr_ready = 1'b1;
        w_accept   = I_wr_valid;
        if (I_wr_valid && w_last) w_next_state = S_SWAP;
      end
      S_SWAP: if (!r_rd_busy || I_rd_done) begin
        w_swap       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Mod-N scatter counters: bank wraps into block, block wraps into addr.
  always_ff @(posedge I_clk) begin
    if (I_reset || r_state == S_IDLE) begin
      r_bank  <= '0;
      r_block <= '0;
      r_addr  <= '0;
    end else if (w_accept) begin
      if (w_bank == BANK_MAX) begin
        r_bank <= '0;
        if (w_block == BLOCK_MAX) begin
          r_block <= '0;
          r_addr  <= (w_addr == ADDR_MAX) ? '0 : w_addr + ADDR_W'(1);
        end else begin
          r_block <= w_block + BLOCK_W'(1);
          r_addr  <= w_addr;
        end
      end else begin
        r_bank  <= w_bank + BANK_W'(1);
        r_block <= w_block;
        r_addr  <= w_addr;
      end
    end else if (w_restart) begin
      r_bank  <= '0;
      r_block <= '0;
      r_addr  <= '0;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_wr_en    <= 1'b0;
      r_wr_bank  <= '0;
      r_wr_block <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_bank  <= w_bank;
        r_wr_block <= w_block;
        r_wr_addr  <= w_addr;
        r_wr_data  <= I_wr_data;
      end
    end
  end

  // Swap wins over a coincident rd_done, so the reader stays busy with the fresh frame.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_wr_buf     <= 1'b0;
      r_rd_buf     <= 1'b1;
      r_rd_start   <= 1'b0;
      r_rd_busy    <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_rd_start <= w_swap;
      if (w_swap) begin
        r_rd_buf  <= r_wr_buf;
        r_wr_buf  <= ~r_wr_buf;
        r_rd_busy <= 1'b1;
      end else if (I_rd_done) begin
        r_rd_busy <= 1'b0;
      end
      if (w_restart && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign O_wr_ready   = w_wr_ready;
  assign O_wr_en      = r_wr_en;
  assign O_wr_buf     = r_wr_buf;
  assign O_wr_bank    = r_wr_bank;
  assign O_wr_block   = r_wr_block;
  assign O_wr_addr    = r_wr_addr;
  assign O_wr_data    = r_wr_data;
  assign O_rd_buf     = r_rd_buf;
  assign O_rd_start   = r_rd_start;
  assign O_drop_count = r_drop_count;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl with a 2x2x3 geometry: vector table, directed corner sequences,
// and random traffic checked every cycle against an arithmetic frame model.
module tb_frame_buffer_ctrl;

  localparam int BANKS  = 2;
  localparam int BLOCKS = 2;
  localparam int WPB    = 3;
  localparam int FW     = BANKS * BLOCKS * WPB;
  localparam int AW     = $clog2(WPB);

  logic          I_clk = 1'b0;
  logic          I_reset, I_frame_start, I_wr_valid, I_rd_done;
  logic [31:0]   I_wr_data;
  logic          O_wr_ready, O_wr_en, O_wr_buf, O_rd_buf, O_rd_start;
  logic [0:0]    O_wr_bank, O_wr_block;
  logic [AW-1:0] O_wr_addr;
  logic [31:0]   O_wr_data;
  logic [15:0]   O_drop_count;

  frame_buffer_ctrl #(
    .BANK_COUNT(BANKS), .BLOCK_COUNT(BLOCKS), .WORDS_PER_BLOCK(WPB)
  ) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_frame_start(I_frame_start),
    .I_wr_valid(I_wr_valid), .I_wr_data(I_wr_data), .O_wr_ready(O_wr_ready),
    .O_wr_en(O_wr_en), .O_wr_buf(O_wr_buf), .O_wr_bank(O_wr_bank),
    .O_wr_block(O_wr_block), .O_wr_addr(O_wr_addr), .O_wr_data(O_wr_data),
    .O_rd_buf(O_rd_buf), .O_rd_start(O_rd_start), .I_rd_done(I_rd_done),
    .O_drop_count(O_drop_count)
  );

  always #5 I_clk = ~I_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame position as a plain word index, geometry derived by division.
  bit          m_filling, m_full, m_wr_buf, m_rd_buf, m_busy, m_rd_start, m_wr_en;
  int          m_n, m_bank, m_block, m_addr, m_drops;
  logic [31:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit swapped;
    swapped    = 1'b0;
    m_wr_en    = 1'b0;
    m_rd_start = 1'b0;
    if (I_reset) begin
      m_filling = 0; m_full = 0; m_n = 0; m_busy = 0;
      m_wr_buf = 0; m_rd_buf = 1; m_drops = 0;
      m_bank = 0; m_block = 0; m_addr = 0; m_data = '0;
      return;
    end
    if (m_filling) begin
      if (I_frame_start) begin
        m_n = 0;
        if (m_drops < 65535) m_drops++;
      end
      if (I_wr_valid) begin
        m_wr_en = 1'b1;
        m_bank  = m_n % BANKS;
        m_block = (m_n / BANKS) % BLOCKS;
        m_addr  = m_n / (BANKS * BLOCKS);
        m_data  = I_wr_data;
        m_n++;
        if (m_n == FW) begin
          m_filling = 0;
          m_full    = 1;
        end
      end
    end else if (m_full) begin
      if (!m_busy || I_rd_done) begin
        swapped    = 1'b1;
        m_rd_buf   = m_wr_buf;
        m_wr_buf   = !m_wr_buf;
        m_rd_start = 1'b1;
        m_busy     = 1'b1;
        m_full     = 0;
      end
    end else if (I_frame_start) begin
      m_filling = 1;
      m_n       = 0;
    end
    if (I_rd_done && !swapped) m_busy = 1'b0;
  endtask

  task automatic compare_model();
    check("model.ready",    O_wr_ready,   m_filling);
    check("model.wr_en",    O_wr_en,      m_wr_en);
    check("model.bank",     O_wr_bank,    m_bank);
    check("model.block",    O_wr_block,   m_block);
    check("model.addr",     O_wr_addr,    m_addr);
    check("model.data",     O_wr_data,    m_data);
    check("model.wr_buf",   O_wr_buf,     m_wr_buf);
    check("model.rd_buf",   O_rd_buf,     m_rd_buf);
    check("model.rd_start", O_rd_start,   m_rd_start);
    check("model.drops",    O_drop_count, m_drops);
  endtask

  task automatic step(input bit fs, input bit v, input logic [31:0] d, input bit done, input bit rst);
    I_frame_start = fs;
    I_wr_valid    = v;
    I_wr_data     = d;
    I_rd_done     = done;
    I_reset       = rst;
    @(posedge I_clk);
    model_step();
    @(negedge I_clk);
    compare_model();
  endtask

  task automatic words(input int count, input int base);
    for (int i = 0; i < count; i++) step(0, 1, 32'(base + i), 0, 0);
  endtask

  typedef struct {
    bit          fs, v;
    logic [31:0] d;
    bit          en;
    int          bank, block, addr;
    bit          rdy, rs, rb, wb;
  } vec_t;

  function automatic vec_t mk(bit fs, bit v, logic [31:0] d, bit en, int bank, int block,
                              int addr, bit rdy, bit rs, bit rb, bit wb);
    vec_t t;
    t.fs = fs; t.v = v; t.d = d; t.en = en; t.bank = bank; t.block = block; t.addr = addr;
    t.rdy = rdy; t.rs = rs; t.rb = rb; t.wb = wb;
    return t;
  endfunction

  vec_t tbl[15];
  int   wr_cnt;

  initial begin
    //              fs v  data   en bk bl ad  rdy rs rb wb
    tbl[0]  = mk(1, 0, 32'h0,  0, 0, 0, 0,  1, 0, 1, 0);
    tbl[1]  = mk(0, 1, 32'h10, 1, 0, 0, 0,  1, 0, 1, 0);
    tbl[2]  = mk(0, 1, 32'h11, 1, 1, 0, 0,  1, 0, 1, 0);
    tbl[3]  = mk(0, 1, 32'h12, 1, 0, 1, 0,  1, 0, 1, 0);
    tbl[4]  = mk(0, 1, 32'h13, 1, 1, 1, 0,  1, 0, 1, 0);
    tbl[5]  = mk(0, 1, 32'h14, 1, 0, 0, 1,  1, 0, 1, 0);
    tbl[6]  = mk(0, 1, 32'h15, 1, 1, 0, 1,  1, 0, 1, 0);
    tbl[7]  = mk(0, 1, 32'h16, 1, 0, 1, 1,  1, 0, 1, 0);
    tbl[8]  = mk(0, 1, 32'h17, 1, 1, 1, 1,  1, 0, 1, 0);
    tbl[9]  = mk(0, 1, 32'h18, 1, 0, 0, 2,  1, 0, 1, 0);
    tbl[10] = mk(0, 1, 32'h19, 1, 1, 0, 2,  1, 0, 1, 0);
    tbl[11] = mk(0, 1, 32'h1A, 1, 0, 1, 2,  1, 0, 1, 0);
    tbl[12] = mk(0, 1, 32'h1B, 1, 1, 1, 2,  0, 0, 1, 0);
    tbl[13] = mk(0, 0, 32'h0,  0, 0, 0, 0,  0, 1, 0, 1);
    tbl[14] = mk(0, 0, 32'h0,  0, 0, 0, 0,  0, 0, 0, 1);

    // Reset state.
    step(0, 0, 0, 0, 1);
    check("rst.ready", O_wr_ready, 0);
    check("rst.wr_en", O_wr_en, 0);
    check("rst.rd_buf", O_rd_buf, 1);
    check("rst.wr_buf", O_wr_buf, 0);
    check("rst.rd_start", O_rd_start, 0);
    check("rst.drops", O_drop_count, 0);
    step(0, 0, 0, 0, 0);

    // First frame: scatter order and first swap.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].fs, tbl[i].v, tbl[i].d, 0, 0);
      check($sformatf("tbl[%0d].en", i), O_wr_en, tbl[i].en);
      if (tbl[i].en) begin
        check($sformatf("tbl[%0d].bank", i), O_wr_bank, tbl[i].bank);
        check($sformatf("tbl[%0d].block", i), O_wr_block, tbl[i].block);
        check($sformatf("tbl[%0d].addr", i), O_wr_addr, tbl[i].addr);
        check($sformatf("tbl[%0d].data", i), O_wr_data, tbl[i].d);
      end
      check($sformatf("tbl[%0d].ready", i), O_wr_ready, tbl[i].rdy);
      check($sformatf("tbl[%0d].rd_start", i), O_rd_start, tbl[i].rs);
      check($sformatf("tbl[%0d].rd_buf", i), O_rd_buf, tbl[i].rb);
      check($sformatf("tbl[%0d].wr_buf", i), O_wr_buf, tbl[i].wb);
    end

    // Second frame while the reader is busy: stall until rd_done.
    step(1, 0, 0, 0, 0);
    words(FW, 32'h100);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'hDEAD, 0, 0);
      check("stall.ready", O_wr_ready, 0);
      check("stall.rd_start", O_rd_start, 0);
      check("stall.wr_en", O_wr_en, 0);
    end
    step(0, 0, 0, 1, 0);
    check("release.rd_start", O_rd_start, 1);
    check("release.rd_buf", O_rd_buf, 1);
    check("release.wr_buf", O_wr_buf, 0);

    // rd_done in the first SWAP cycle: swap wins and the reader stays busy.
    step(1, 0, 0, 0, 0);
    words(FW, 32'h200);
    step(0, 0, 0, 1, 0);
    check("coinc.rd_start", O_rd_start, 1);
    check("coinc.rd_buf", O_rd_buf, 0);
    check("coinc.wr_buf", O_wr_buf, 1);
    step(1, 0, 0, 0, 0);
    words(FW, 32'h300);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("coinc.busy_stall", O_rd_start, 0);
    step(0, 0, 0, 1, 0);
    check("coinc.release", O_rd_start, 1);

    // Early frame_start after 5 words drops the partial frame.
    step(1, 0, 0, 0, 0);
    words(5, 32'h400);
    step(1, 1, 32'h4AA, 0, 0);
    check("drop.count", O_drop_count, 1);
    check("drop.wr_en", O_wr_en, 1);
    check("drop.bank", O_wr_bank, 0);
    check("drop.block", O_wr_block, 0);
    check("drop.addr", O_wr_addr, 0);
    check("drop.data", O_wr_data, 32'h4AA);
    words(FW - 2, 32'h500);
    check("drop.still_filling", O_wr_ready, 1);
    words(1, 32'h5FF);
    check("drop.full", O_wr_ready, 0);
    step(0, 0, 0, 1, 0);
    check("drop.swap", O_rd_start, 1);

    // Valid toggling every cycle: gaps on wr_en, same address order.
    step(1, 0, 0, 0, 0);
    wr_cnt = 0;
    for (int i = 0; i < 2 * FW; i++) begin
      step(0, (i % 2) == 0, 32'(32'h600 + i), 0, 0);
      if (O_wr_en) wr_cnt++;
      if (i == 2 * FW - 2) begin
        check("toggle.last_bank", O_wr_bank, 1);
        check("toggle.last_block", O_wr_block, 1);
        check("toggle.last_addr", O_wr_addr, 2);
      end
    end
    check("toggle.writes", wr_cnt, FW);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h700, 0, 0);
      check("idle.no_wr_en", O_wr_en, 0);
    end

    // Reset after 7 words, then a fresh frame from (0,0,0).
    step(1, 0, 0, 0, 0);
    words(7, 32'h800);
    step(0, 1, 32'h8FF, 0, 1);
    check("mid_rst.wr_en", O_wr_en, 0);
    check("mid_rst.ready", O_wr_ready, 0);
    check("mid_rst.rd_buf", O_rd_buf, 1);
    check("mid_rst.wr_buf", O_wr_buf, 0);
    check("mid_rst.rd_start", O_rd_start, 0);
    check("mid_rst.drops", O_drop_count, 0);
    check("mid_rst.addr", O_wr_addr, 0);
    check("mid_rst.data", O_wr_data, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h55, 0, 0);
    check("post_rst.wr_en", O_wr_en, 1);
    check("post_rst.bank", O_wr_bank, 0);
    check("post_rst.block", O_wr_block, 0);
    check("post_rst.addr", O_wr_addr, 0);
    check("post_rst.wr_buf", O_wr_buf, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, $urandom,
           $urandom_range(0, 7) == 0, $urandom_range(0, 499) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
